// File: rtl/rld.sv
// rld: RLE decompressor. Expands (value, count) byte pairs read from dpsram port A back into dpsram.
// Optional build macro RLD_ERR_CHECK_EN: zero counts or odd stream length raise err and end early.
module rld #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       rle_addr,
  input  logic [31:0]       rle_size,
  input  logic [31:0]       out_addr,
  output logic [31:0]       out_size,
  output logic              done,
  output logic              err,
  output logic              port_A_clk,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we
);

`ifdef RLD_ERR_CHECK_EN
  localparam bit ErrCheck = 1'b1;
`else
  localparam bit ErrCheck = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StParse, StEmit, StWr, StFlush, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rle_base_q, rle_base_d, size_q, size_d, out_base_q, out_base_d;
  logic [31:0] in_idx_q, in_idx_d, wr_idx_q, wr_idx_d, cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d, pack_q, pack_d;
  logic        buf_vld_q, buf_vld_d, err_q, err_d;
  logic [7:0]  value_q, value_d, run_q, run_d;
  logic [2:0]  pack_cnt_q, pack_cnt_d;
  logic [7:0]  cur_byte;
  logic [31:0] mem_addr;
  logic        unused_addr;

  assign cur_byte = buf_q[{in_idx_q[1:0], 3'b000} +: 8];

  always_comb begin
    state_d        = state_q;
    rle_base_d     = rle_base_q;
    size_d         = size_q;
    out_base_d     = out_base_q;
    in_idx_d       = in_idx_q;
    wr_idx_d       = wr_idx_q;
    cnt_d          = cnt_q;
    buf_d          = buf_q;
    pack_d         = pack_q;
    buf_vld_d      = buf_vld_q;
    err_d          = err_q;
    value_d        = value_q;
    run_d          = run_q;
    pack_cnt_d     = pack_cnt_q;
    mem_addr       = 32'd0;
    port_A_data_in = 32'd0;
    port_A_we      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          rle_base_d = rle_addr;
          size_d     = rle_size;
          out_base_d = out_addr;
          in_idx_d   = 32'd0;
          wr_idx_d   = 32'd0;
          cnt_d      = 32'd0;
          err_d      = 1'b0;
          buf_vld_d  = 1'b0;
          pack_d     = 32'd0;
          pack_cnt_d = 3'd0;
          run_d      = 8'd0;
          if (rle_size == 32'd0) begin
            state_d = StDone;
          end else if (ErrCheck && rle_size[0]) begin
            err_d   = 1'b1;
            state_d = StFlush;
          end else begin
            state_d = StRdReq;
          end
        end
      end
      StRdReq: begin
        mem_addr = rle_base_q + (in_idx_q & ~32'd3);
        state_d  = StRdWait;
      end
      StRdWait: begin
        buf_d     = port_A_data_out;
        buf_vld_d = 1'b1;
        state_d   = StParse;
      end
      StParse: begin
        if (in_idx_q == size_q) begin
          state_d = StFlush;
        end else if (!buf_vld_q) begin
          state_d = StRdReq;
        end else begin
          in_idx_d = in_idx_q + 32'd1;
          if (in_idx_q[1:0] == 2'd3) buf_vld_d = 1'b0;
          if (!in_idx_q[0]) begin
            value_d = cur_byte;
          end else if (cur_byte != 8'd0) begin
            run_d   = cur_byte;
            state_d = StEmit;
          end else if (ErrCheck) begin
            err_d   = 1'b1;
            state_d = StFlush;
          end
        end
      end
      StEmit: begin
        pack_d[{pack_cnt_q[1:0], 3'b000} +: 8] = value_q;
        pack_cnt_d = pack_cnt_q + 3'd1;
        run_d      = run_q - 8'd1;
        cnt_d      = cnt_q + 32'd1;
        // A full packer wins over an exhausted run; WR picks the follow-up state.
        if (pack_cnt_q == 3'd3) state_d = StWr;
        else if (run_q == 8'd1) state_d = StParse;
      end
      StWr: begin
        mem_addr       = out_base_q + (wr_idx_q << 2);
        port_A_data_in = pack_q;
        port_A_we      = 1'b1;
        pack_d         = 32'd0;
        pack_cnt_d     = 3'd0;
        wr_idx_d       = wr_idx_q + 32'd1;
        state_d        = (run_q != 8'd0) ? StEmit : StParse;
      end
      StFlush: begin
        if (pack_cnt_q != 3'd0) begin
          mem_addr       = out_base_q + (wr_idx_q << 2);
          port_A_data_in = pack_q;
          port_A_we      = 1'b1;
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rle_base_q <= 32'd0;
      size_q     <= 32'd0;
      out_base_q <= 32'd0;
      in_idx_q   <= 32'd0;
      wr_idx_q   <= 32'd0;
      cnt_q      <= 32'd0;
      buf_q      <= 32'd0;
      pack_q     <= 32'd0;
      buf_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      value_q    <= 8'd0;
      run_q      <= 8'd0;
      pack_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      rle_base_q <= rle_base_d;
      size_q     <= size_d;
      out_base_q <= out_base_d;
      in_idx_q   <= in_idx_d;
      wr_idx_q   <= wr_idx_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      pack_q     <= pack_d;
      buf_vld_q  <= buf_vld_d;
      err_q      <= err_d;
      value_q    <= value_d;
      run_q      <= run_d;
      pack_cnt_q <= pack_cnt_d;
    end
  end

  // Addresses wrap at ADDR_W and are forced word aligned.
  assign port_A_addr = {mem_addr[ADDR_W-1:2], 2'b00};
  assign unused_addr = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};
  assign port_A_clk  = clk;
  assign out_size    = cnt_q;
  assign done        = (state_q == StDone);
  assign err         = err_q;

endmodule

// File: tb/tb_rld.sv
// tb_rld: self-checking bench for rld; byte-level RLE model plus a synchronous dpsram model.
module tb_rld;
`ifdef RLD_ERR_CHECK_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk, reset, start;
  logic [31:0] rle_addr, rle_size, out_addr, out_size;
  logic        done, err, port_A_clk, port_A_we;
  logic [31:0] port_A_data_in, port_A_data_out;
  logic [15:0] port_A_addr;

  rld #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .rle_addr(rle_addr), .rle_size(rle_size),
    .out_addr(out_addr), .out_size(out_size), .done(done), .err(err), .port_A_clk(port_A_clk),
    .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out),
    .port_A_addr(port_A_addr), .port_A_we(port_A_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  // dpsram: one write port for the DUT, one preload port for the bench.
  logic [31:0] mem [0:16383];
  logic        tb_wr;
  logic [13:0] tb_waddr;
  logic [31:0] tb_wdata;
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (tb_wr) mem[tb_waddr] <= tb_wdata;
    else if (port_A_we) mem[port_A_addr[15:2]] <= port_A_data_in;
    rd_q <= mem[port_A_addr[15:2]];
  end
  assign port_A_data_out = rd_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every DUT write must be the next one the model predicted.
  always @(negedge clk) begin
    if (!reset && port_A_we) begin
      wr_cnt++;
      if (exp_addr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", port_A_addr,
                 port_A_data_in);
      end else begin
        logic [31:0] ea, ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("wr_addr", {16'd0, port_A_addr}, {16'd0, ea[15:0]});
        check("wr_data", port_A_data_in, ed);
      end
    end
  end

  function automatic logic [7:0] get_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[15:2]];
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic poke(input logic [31:0] byte_addr, input logic [31:0] data);
    tb_wr = 1'b1;
    tb_waddr = byte_addr[15:2];
    tb_wdata = data;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  task automatic load_stream(input logic [31:0] base, input logic [7:0] b[$]);
    for (int w = 0; w * 4 < b.size(); w++) begin
      logic [31:0] d;
      d = 32'd0;
      for (int k = 0; k < 4; k++) if (w * 4 + k < b.size()) d[8*k +: 8] = b[w*4+k];
      poke(base + 32'(w * 4), d);
    end
  endtask

  // Expands the stream straight from its definition and queues the expected words.
  task automatic run_op(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] oa,
                        input int budget, input bit inject, output int n_out, output int n_wr);
    logic [7:0] outb[$];
    logic       e;
    int         wr0, bad;
    e = 1'b0;
    if (ErrEn && rs[0]) e = 1'b1;
    else begin
      for (int k = 0; k + 1 < int'(rs); k += 2) begin
        logic [7:0] v, c;
        v = get_byte(ra + 32'(k));
        c = get_byte(ra + 32'(k + 1));
        if (ErrEn && c == 8'd0) begin
          e = 1'b1;
          break;
        end
        for (int j = 0; j < int'(c); j++) outb.push_back(v);
      end
    end
    n_out = outb.size();
    n_wr = (n_out + 3) / 4;
    for (int w = 0; w < n_wr; w++) begin
      logic [31:0] d;
      d = 32'd0;
      for (int k = 0; k < 4; k++) if (w * 4 + k < n_out) d[8*k +: 8] = outb[w*4+k];
      exp_addr_q.push_back(oa + 32'(w * 4));
      exp_data_q.push_back(d);
    end
    wr0 = wr_cnt;
    rle_addr = ra;
    rle_size = rs;
    out_addr = oa;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rle_addr = 32'h8000;
    rle_size = 32'd9;
    out_addr = 32'h8000;
    for (int i = 0; i < budget && !done; i++) begin
      if (inject && i == 3) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("out_size", out_size, 32'(n_out));
    check("err", {31'd0, err}, {31'd0, e});
    check("write_count", 32'(wr_cnt - wr0), 32'(n_wr));
    check("writes_left", 32'(exp_addr_q.size()), 32'd0);
    bad = 0;
    for (int i = 0; i < n_wr * 4; i++) begin
      logic [7:0] eb;
      eb = (i < n_out) ? outb[i] : 8'h00;
      if (get_byte(oa + 32'(i)) !== eb) bad++;
    end
    check("mem_bytes_bad", 32'(bad), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] frame[$];
    int n_out, n_wr, w0, bad;

    tb_wr = 1'b0;
    tb_waddr = '0;
    tb_wdata = '0;
    reset = 1'b1;
    start = 1'b0;
    rle_addr = '0;
    rle_size = '0;
    out_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_out_size", out_size, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_we", {31'd0, port_A_we}, 32'd0);
    check("rst_addr", {16'd0, port_A_addr}, 32'd0);
    check("rst_data_in", port_A_data_in, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Short stream: 0x41 x3, 0x42 x1.
    poke(32'hC8, 32'h01420341);
    run_op(32'hC8, 32'd4, 32'h190, 200, 1'b0, n_out, n_wr);
    check("short_word", mem[32'h190 >> 2], 32'h42414141);
    check("short_size", out_size, 32'd4);

    // Max count, partial final word.
    poke(32'h400, 32'h0000FF5A);
    run_op(32'h400, 32'd2, 32'h800, 1000, 1'b0, n_out, n_wr);
    check("max_size", out_size, 32'd255);
    check("max_word0", mem[32'h800 >> 2], 32'h5A5A5A5A);
    check("max_word63", mem[(32'h800 >> 2) + 63], 32'h005A5A5A);

    // Empty input must finish within two cycles.
    w0 = wr_cnt;
    run_op(32'h100, 32'd0, 32'h900, 2, 1'b0, n_out, n_wr);
    check("empty_size", out_size, 32'd0);
    check("empty_writes", 32'(wr_cnt - w0), 32'd0);

    // Second count is zero.
    poke(32'h200, 32'h00410341);
    run_op(32'h200, 32'd4, 32'hA00, 200, 1'b0, n_out, n_wr);
    check("zero_cnt_size", out_size, 32'd3);
    check("zero_cnt_word", mem[32'hA00 >> 2], 32'h00414141);
    check("zero_cnt_err", {31'd0, err}, {31'd0, ErrEn});

    // Round trip: compress a frame with the plain run-length rule, then expand it.
    for (int i = 0; i < 39; i++) frame.push_back(8'((i < 10) ? 8'h11 : (i < 13) ? 8'h22 : i * 37 + 5));
    load_stream(32'h0, frame);
    s.delete();
    for (int i = 0; i < 39;) begin
      int c;
      c = 1;
      while (i + c < 39 && frame[i+c] == frame[i] && c < 255) c++;
      s.push_back(frame[i]);
      s.push_back(8'(c));
      i += c;
    end
    load_stream(32'hC8, s);
    run_op(32'hC8, 32'(s.size()), 32'h190, 2000, 1'b0, n_out, n_wr);
    check("rt_size", out_size, 32'd39);
    bad = 0;
    for (int i = 0; i < 39; i++) if (get_byte(32'h190 + 32'(i)) !== frame[i]) bad++;
    check("rt_bytes_bad", 32'(bad), 32'd0);
    check("rt_byte39", {24'd0, get_byte(32'h190 + 32'd39)}, 32'd0);

    // Randomized streams, some with a stray start pulse while busy.
    for (int t = 0; t < 30; t++) begin
      logic [31:0] ra, oa, rs;
      ra = 32'h1000 + 32'(4 * $urandom_range(0, 63));
      oa = 32'h4000 + 32'(4 * $urandom_range(0, 63));
      rs = 32'($urandom_range(1, 40));
      s.delete();
      for (int k = 0; k < int'(rs); k++) begin
        if (k % 2 == 0) s.push_back(8'($urandom));
        else if ($urandom_range(0, 9) == 0) s.push_back(8'($urandom_range(0, 1) * 255));
        else s.push_back(8'($urandom_range(1, 12)));
      end
      load_stream(ra, s);
      run_op(ra, rs, oa, 20000, t[0], n_out, n_wr);
    end

    // Reset mid-run: abort while emitting, then prove no further writes and recovery.
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int w = 0; w < 64; w++) begin
      exp_addr_q.push_back(32'hC00 + 32'(w * 4));
      exp_data_q.push_back((w == 63) ? 32'h005A5A5A : 32'h5A5A5A5A);
    end
    rle_addr = 32'h400;
    rle_size = 32'd2;
    out_addr = 32'hC00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_addr_q.delete();
    exp_data_q.delete();
    check("abort_out_size", out_size, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    check("abort_we", {31'd0, port_A_we}, 32'd0);
    check("abort_addr", {16'd0, port_A_addr}, 32'd0);
    reset = 1'b0;
    w0 = wr_cnt;
    repeat (300) @(negedge clk);
    check("abort_writes", 32'(wr_cnt - w0), 32'd0);
    check("abort_idle_done", {31'd0, done}, 32'd0);
    run_op(32'hC8 + 32'h38, 32'd0, 32'h900, 2, 1'b0, n_out, n_wr);
    poke(32'hC8, 32'h01420341);
    run_op(32'hC8, 32'd4, 32'h190, 200, 1'b0, n_out, n_wr);
    check("recover_word", mem[32'h190 >> 2], 32'h42414141);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
